// File: rtl/demux_stream_1xn.sv
// demux_stream_1xn
//   Registered 1-to-N stream demultiplexer. Each accepted input beat is
//   steered to one output channel, chosen either by in_sel (addressed mode)
//   or by an internal round-robin pointer. Every channel owns a one-entry
//   output register, so a slow consumer only stalls the input while its
//   channel is the current target.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   producer has a beat
//   in_ready   block accepts the beat this cycle
//   in_data    beat payload (W bits)
//   in_sel     target channel in addressed mode (SEL_W bits)
//   mode       0 = addressed, 1 = round-robin (sampled per beat)
//   out_valid  per-channel valid (N bits)
//   out_ready  per-channel consumer ready (N bits)
//   out_data   channel k occupies bits [k*W +: W]
//   err        one-cycle pulse after an out-of-range in_sel beat is dropped
//   rr_ptr     current round-robin pointer (debug/verification)

module demux_stream_1xn #(
  parameter  int N     = 4,
  parameter  int W     = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               mode,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [N*W-1:0]     out_data,
  output logic               err,
  output logic [SEL_W-1:0]   rr_ptr
);

  // One extra bit so the range compare is meaningful when N is a power of 2.
  localparam logic [SEL_W:0]   N_EXT = (SEL_W + 1)'(N);
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(N - 1);

  logic [SEL_W-1:0] target;
  logic             sel_oor;
  logic             target_full;
  logic             target_drain;
  logic             accept;
  logic [N-1:0]     load;

  // Target selection and the ready equation. in_ready depends only on the
  // channel state, out_ready, mode, in_sel and rr_ptr, never on in_valid or
  // in_data. An out-of-range select is always accepted so it can be dropped.
  always_comb begin
    target       = mode ? rr_ptr : in_sel;
    sel_oor      = !mode && ({1'b0, in_sel} >= N_EXT);
    target_full  = 1'b0;
    target_drain = 1'b0;
    load         = '0;
    for (int k = 0; k < N; k++) begin
      if (target == SEL_W'(k)) begin
        target_full  = out_valid[k];
        target_drain = out_ready[k];
      end
    end
    in_ready = sel_oor | !target_full | target_drain;
    accept   = in_valid & in_ready;
    for (int k = 0; k < N; k++) begin
      load[k] = accept & !sel_oor & (target == SEL_W'(k));
    end
  end

  // Channel registers, round-robin pointer and drop flag. A load takes
  // priority over a drain on the same channel, so a draining full channel
  // refills with no bubble. Empty channels keep their last data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      rr_ptr    <= '0;
      err       <= 1'b0;
    end else begin
      err <= accept & sel_oor;
      for (int k = 0; k < N; k++) begin
        if (load[k]) begin
          out_data[k*W +: W] <= in_data;
          out_valid[k]       <= 1'b1;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
      if (accept && mode) begin
        rr_ptr <= (rr_ptr == LAST) ? '0 : rr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_demux_stream_1xn.sv
// tb_demux_stream_1xn
//   Self-checking bench for demux_stream_1xn. The main instance (N=4, W=8)
//   is compared every cycle against a behavioural model that treats each
//   channel as a one-slot holding place and the round-robin pointer as an
//   integer modulo N. A second instance (N=5) exercises the out-of-range
//   select drop.

module tb_demux_stream_1xn;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic [1:0]     in_sel;
  logic           mode;
  logic [N-1:0]   out_valid;
  logic [N-1:0]   out_ready;
  logic [N*W-1:0] out_data;
  logic           err;
  logic [1:0]     rr_ptr;

  logic           d5_in_valid;
  logic           d5_in_ready;
  logic [7:0]     d5_in_data;
  logic [2:0]     d5_in_sel;
  logic           d5_mode;
  logic [4:0]     d5_out_valid;
  logic [4:0]     d5_out_ready;
  logic [39:0]    d5_out_data;
  logic           d5_err;
  logic [2:0]     d5_rr_ptr;

  int errors;
  int checks;

  // Reference model state
  bit         m_full [N];
  logic [7:0] m_data [N];
  int         m_rr;
  bit         m_err;

  demux_stream_1xn #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err       (err),
    .rr_ptr    (rr_ptr)
  );

  demux_stream_1xn #(.N(5), .W(8)) dut5 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (d5_in_valid),
    .in_ready  (d5_in_ready),
    .in_data   (d5_in_data),
    .in_sel    (d5_in_sel),
    .mode      (d5_mode),
    .out_valid (d5_out_valid),
    .out_ready (d5_out_ready),
    .out_data  (d5_out_data),
    .err       (d5_err),
    .rr_ptr    (d5_rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Whether the model would take a beat offered with these inputs.
  function automatic bit modelReady(input logic m, input logic [1:0] s,
                                    input logic [N-1:0] rdy);
    int tgt;
    tgt = m ? m_rr : int'(s);
    if (!m && tgt >= N) return 1'b1;
    return !m_full[tgt] || rdy[tgt];
  endfunction

  // Advance the model by one clock edge: consumers take what they are ready
  // for, then the accepted beat (if any) lands in its target slot.
  task automatic modelStep(input logic r, input logic v, input logic [7:0] d,
                           input logic [1:0] s, input logic m,
                           input logic [N-1:0] rdy);
    bit acc;
    bit oor;
    int tgt;
    if (r) begin
      for (int k = 0; k < N; k++) begin
        m_full[k] = 1'b0;
        m_data[k] = 8'h00;
      end
      m_rr  = 0;
      m_err = 1'b0;
      return;
    end
    tgt = m ? m_rr : int'(s);
    oor = !m && tgt >= N;
    acc = v && modelReady(m, s, rdy);
    m_err = acc && oor;
    for (int k = 0; k < N; k++) begin
      if (m_full[k] && rdy[k]) m_full[k] = 1'b0;
    end
    if (acc && !oor) begin
      m_full[tgt] = 1'b1;
      m_data[tgt] = d;
    end
    if (acc && m) m_rr = (m_rr + 1) % N;
  endtask

  task automatic checkConst(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Compare all registered outputs of the main instance with the model.
  task automatic checkOutput(input string tag);
    logic [N-1:0]   exp_valid;
    logic [N*W-1:0] exp_data;
    for (int k = 0; k < N; k++) begin
      exp_valid[k]        = m_full[k];
      exp_data[k*W +: W]  = m_data[k];
    end
    checks++;
    assert (out_valid === exp_valid) else begin
      errors++;
      $error("[TB] FAIL %s out_valid got=%b exp=%b", tag, out_valid, exp_valid);
    end
    checks++;
    assert (out_data === exp_data) else begin
      errors++;
      $error("[TB] FAIL %s out_data got=%h exp=%h", tag, out_data, exp_data);
    end
    checks++;
    assert (rr_ptr === 2'(m_rr)) else begin
      errors++;
      $error("[TB] FAIL %s rr_ptr got=%0d exp=%0d", tag, rr_ptr, m_rr);
    end
    checks++;
    assert (err === m_err) else begin
      errors++;
      $error("[TB] FAIL %s err got=%b exp=%b", tag, err, m_err);
    end
  endtask

  // Drive one cycle of inputs, check in_ready before the edge, then step the
  // model across the edge and check the registered outputs.
  task automatic applyStimulus(input string tag, input logic r, input logic v,
                               input logic [7:0] d, input logic [1:0] s,
                               input logic m, input logic [N-1:0] rdy);
    bit exp_ready;
    rst       = r;
    in_valid  = v;
    in_data   = d;
    in_sel    = s;
    mode      = m;
    out_ready = rdy;
    #1;
    exp_ready = modelReady(m, s, rdy);
    checks++;
    assert (in_ready === exp_ready) else begin
      errors++;
      $error("[TB] FAIL %s in_ready got=%b exp=%b", tag, in_ready, exp_ready);
    end
    @(posedge clk);
    modelStep(r, v, d, s, m, rdy);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    in_sel       = '0;
    mode         = 1'b0;
    out_ready    = 4'hF;
    d5_in_valid  = 1'b0;
    d5_in_data   = '0;
    d5_in_sel    = '0;
    d5_mode      = 1'b0;
    d5_out_ready = 5'h1F;

    // Initial reset
    @(posedge clk);
    #1;
    modelStep(1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
    checkOutput("reset");
    checkConst("reset_valid", 64'(out_valid), 64'h0);
    checkConst("reset_rr", 64'(rr_ptr), 64'h0);

    // Addressed sweep
    for (int i = 0; i < 4; i++) begin
      applyStimulus("sweep", 1'b0, 1'b1, 8'(8'hA0 + i), 2'(i), 1'b0, 4'hF);
      checkConst("sweep_valid", 64'(out_valid), 64'(4'b0001 << i));
      checkConst("sweep_data", 64'(out_data[i*8 +: 8]), 64'(8'hA0 + i));
    end
    applyStimulus("idle", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

    // Backpressure on channel 2, then drain and reload on the same edge
    applyStimulus("bp1", 1'b0, 1'b1, 8'h11, 2'd2, 1'b0, 4'b1011);
    applyStimulus("bp2", 1'b0, 1'b1, 8'h22, 2'd2, 1'b0, 4'b1011);
    checkConst("bp_hold", 64'(out_data[23:16]), 64'h11);
    applyStimulus("bp3", 1'b0, 1'b1, 8'h22, 2'd2, 1'b0, 4'hF);
    checkConst("bp_nobubble", 64'(out_valid), 64'b0100);
    checkConst("bp_reload", 64'(out_data[23:16]), 64'h22);
    applyStimulus("bp4", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

    // Round-robin order
    for (int i = 1; i <= 6; i++) begin
      applyStimulus("rr", 1'b0, 1'b1, 8'(i), 2'd0, 1'b1, 4'hF);
      checkConst("rr_chan", 64'(out_valid), 64'(4'b0001 << ((i - 1) % 4)));
    end
    checkConst("rr_end", 64'(rr_ptr), 64'd2);

    // Round-robin stall on channel 3
    applyStimulus("fill3", 1'b0, 1'b1, 8'h30, 2'd3, 1'b0, 4'b0111);
    applyStimulus("rr7", 1'b0, 1'b1, 8'h07, 2'd0, 1'b1, 4'b0111);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("stall", 1'b0, 1'b1, 8'h08, 2'd0, 1'b1, 4'b0111);
      checkConst("stall_rr", 64'(rr_ptr), 64'd3);
      checkConst("stall_ch0", 64'(out_valid[0]), 64'd0);
    end
    applyStimulus("unstall", 1'b0, 1'b1, 8'h08, 2'd0, 1'b1, 4'hF);
    checkConst("unstall_data", 64'(out_data[31:24]), 64'h08);
    applyStimulus("idle", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

    // Reset mid-operation
    applyStimulus("fill0", 1'b0, 1'b1, 8'h5A, 2'd0, 1'b1, 4'h0);
    applyStimulus("fill1", 1'b0, 1'b1, 8'h5B, 2'd0, 1'b1, 4'h0);
    applyStimulus("midrst", 1'b1, 1'b1, 8'h77, 2'd0, 1'b1, 4'h0);
    checkConst("midrst_valid", 64'(out_valid), 64'h0);
    checkConst("midrst_data", 64'(out_data), 64'h0);
    checkConst("midrst_rr", 64'(rr_ptr), 64'h0);
    applyStimulus("postrst", 1'b0, 1'b1, 8'h99, 2'd1, 1'b0, 4'hF);
    checkConst("postrst_valid", 64'(out_valid), 64'b0010);

    // Mode switch
    applyStimulus("ms_rr0", 1'b0, 1'b1, 8'hC0, 2'd0, 1'b1, 4'hF);
    applyStimulus("ms_rr1", 1'b0, 1'b1, 8'hC1, 2'd0, 1'b1, 4'hF);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("ms_addr", 1'b0, 1'b1, 8'(8'hD0 + i), 2'd0, 1'b0, 4'hF);
      checkConst("ms_hold_rr", 64'(rr_ptr), 64'd2);
    end
    applyStimulus("ms_back", 1'b0, 1'b1, 8'hE2, 2'd0, 1'b1, 4'hF);
    checkConst("ms_chan", 64'(out_valid), 64'b0100);
    applyStimulus("idle", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

    // Out-of-range select on the N=5 instance
    d5_in_valid = 1'b1;
    d5_in_sel   = 3'd6;
    d5_in_data  = 8'hFF;
    d5_mode     = 1'b0;
    #1;
    checkConst("oor_ready", 64'(d5_in_ready), 64'd1);
    @(posedge clk);
    #1;
    d5_in_valid = 1'b0;
    checkConst("oor_valid", 64'(d5_out_valid), 64'd0);
    checkConst("oor_err", 64'(d5_err), 64'd1);
    checkConst("oor_rr", 64'(d5_rr_ptr), 64'd0);
    @(posedge clk);
    #1;
    checkConst("oor_err_pulse", 64'(d5_err), 64'd0);
    d5_in_valid = 1'b1;
    d5_in_sel   = 3'd4;
    d5_in_data  = 8'hAB;
    @(posedge clk);
    #1;
    d5_in_valid = 1'b0;
    checkConst("n5_ch4_valid", 64'(d5_out_valid), 64'b10000);
    checkConst("n5_ch4_data", 64'(d5_out_data[39:32]), 64'hAB);
    checkConst("n5_ch4_err", 64'(d5_err), 64'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    1'($urandom_range(0, 49) == 0),
                    1'($urandom_range(0, 3) != 0),
                    8'($urandom),
                    2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)),
                    4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
